// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the control unit and the RV32M multiply/divide unit.
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            Start;
    logic [2:0]      Funct3;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic [4:0]      RdIn;
    logic            Busy;
    logic            Done;
    logic [XLEN-1:0] Result;
    logic [4:0]      RdOut;

    modport master (
        output Start, Funct3, A, B, RdIn,
        input  Busy, Done, Result, RdOut
    );

    modport slave (
        input  Start, Funct3, A, B, RdIn,
        output Busy, Done, Result, RdOut
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: one radix-2 step per cycle, IDLE/CALC/DONE handshake.
// Optional macro MULDIV_EARLY_OUT_EN: divide-by-zero and signed overflow finish after one CALC cycle.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic          CLK,
    input  logic          RST,
    muldiv_unit_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state_q, state_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [2:0]        f3_q, f3_d;
    logic [4:0]        rd_q, rd_d;
    logic              sign_a_q, sign_a_d;
    logic              sign_b_q, sign_b_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic              special_q, special_d;
    logic [XLEN-1:0]   spec_res_q, spec_res_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Operand decode for the request currently on the bus
    logic            in_is_div, in_a_signed, in_b_signed;
    logic            in_div_zero, in_ovf;
    logic [XLEN-1:0] in_mag_a, in_mag_b;

    always_comb begin
        in_is_div   = bus.Funct3[2];
        in_a_signed = (bus.Funct3 == 3'b001) || (bus.Funct3 == 3'b010) ||
                      (bus.Funct3 == 3'b100) || (bus.Funct3 == 3'b110);
        in_b_signed = (bus.Funct3 == 3'b001) || (bus.Funct3 == 3'b100) ||
                      (bus.Funct3 == 3'b110);
        in_mag_a    = (in_a_signed && bus.A[XLEN-1]) ? (~bus.A + 1'b1) : bus.A;
        in_mag_b    = (in_b_signed && bus.B[XLEN-1]) ? (~bus.B + 1'b1) : bus.B;
        in_div_zero = (bus.B == '0);
        in_ovf      = !bus.Funct3[0] && (bus.A == 32'h8000_0000) && (bus.B == 32'hFFFF_FFFF);
    end

    // One iteration step. acc holds {hi,lo} for multiply and {rem,quo} for divide.
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rem_trial;
    logic              div_ge;
    logic [XLEN-1:0]   div_diff;
    logic [2*XLEN-1:0] step_next;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem;
    logic [XLEN-1:0]   fin_res;
    logic              finish;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        rem_trial = acc_q[2*XLEN-1:XLEN-1];
        div_ge    = (rem_trial >= {1'b0, opnd_q});
        // Only the low word of the difference matters: it is < divisor when taken
        div_diff  = rem_trial[XLEN-1:0] - opnd_q;
        if (f3_q[2]) begin
            step_next = div_ge ? {div_diff, acc_q[XLEN-2:0], 1'b1}
                               : {rem_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end else begin
            step_next = {mul_sum, acc_q[XLEN-1:1]};
        end

        prod = (sign_a_q ^ sign_b_q) ? (~step_next + 1'b1) : step_next;
        quo  = (sign_a_q ^ sign_b_q) ? (~step_next[XLEN-1:0] + 1'b1) : step_next[XLEN-1:0];
        rem  = sign_a_q ? (~step_next[2*XLEN-1:XLEN] + 1'b1) : step_next[2*XLEN-1:XLEN];

        if (special_q) begin
            fin_res = spec_res_q;
        end else begin
            case (f3_q)
                3'b000:                 fin_res = prod[XLEN-1:0];
                3'b001, 3'b010, 3'b011: fin_res = prod[2*XLEN-1:XLEN];
                3'b100, 3'b101:         fin_res = quo;
                default:                fin_res = rem;
            endcase
        end

`ifdef MULDIV_EARLY_OUT_EN
        finish = (cnt_q == 6'd31) || special_q;
`else
        finish = (cnt_q == 6'd31);
`endif
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        f3_d       = f3_q;
        rd_d       = rd_q;
        sign_a_d   = sign_a_q;
        sign_b_d   = sign_b_q;
        opnd_d     = opnd_q;
        acc_d      = acc_q;
        special_d  = special_q;
        spec_res_d = spec_res_q;
        result_d   = result_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    state_d    = CALC;
                    busy_d     = 1'b1;
                    cnt_d      = '0;
                    f3_d       = bus.Funct3;
                    rd_d       = bus.RdIn;
                    sign_a_d   = in_a_signed && bus.A[XLEN-1];
                    sign_b_d   = in_b_signed && bus.B[XLEN-1];
                    acc_d      = {{XLEN{1'b0}}, (in_is_div ? in_mag_a : in_mag_b)};
                    opnd_d     = in_is_div ? in_mag_b : in_mag_a;
                    special_d  = in_is_div && (in_div_zero || in_ovf);
                    if (in_div_zero) begin
                        spec_res_d = bus.Funct3[1] ? bus.A : 32'hFFFF_FFFF;
                    end else begin
                        spec_res_d = bus.Funct3[1] ? 32'h0 : 32'h8000_0000;
                    end
                end
            end
            CALC: begin
                acc_d = step_next;
                cnt_d = cnt_q + 6'd1;
                if (finish) begin
                    state_d  = DONE;
                    result_d = fin_res;
                    done_d   = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            f3_q       <= '0;
            rd_q       <= '0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            opnd_q     <= '0;
            acc_q      <= '0;
            special_q  <= 1'b0;
            spec_res_q <= '0;
            result_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            f3_q       <= f3_d;
            rd_q       <= rd_d;
            sign_a_q   <= sign_a_d;
            sign_b_q   <= sign_b_d;
            opnd_q     <= opnd_d;
            acc_q      <= acc_d;
            special_q  <= special_d;
            spec_res_q <= spec_res_d;
            result_q   <= result_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.Busy   = busy_q;
    assign bus.Done   = done_q;
    assign bus.Result = result_q;
    assign bus.RdOut  = rd_q;
endmodule
